// File: rtl/alu_design_if.sv
// Operand/opcode bus and registered result bus for alu_design.
// Index 0 is the MSB on A, B and C.
interface alu_design_if;
  logic       ALU_en;
  logic [0:4] A;
  logic [0:4] B;
  logic       a_en;
  logic [2:0] a_op;
  logic       b_en;
  logic [1:0] b_op;
  logic [0:5] C;
  logic       C_en;

  modport master (output ALU_en, A, B, a_en, a_op, b_en, b_op, input  C, C_en);
  modport slave  (input  ALU_en, A, B, a_en, a_op, b_en, b_op, output C, C_en);
endinterface

// File: rtl/alu_design.sv
// Small signed ALU: 5-bit operands sign-extended to 6 bits, three operation
// sets chosen by a_en/b_en, result registered one cycle after sampling.
module alu_design (
  input  logic         clk,
  input  logic         rst_n,
  alu_design_if.slave  bus
);

  logic signed [5:0] a_ext_s;
  logic signed [5:0] b_ext_s;
  logic signed [5:0] result_s;
  logic              legal_s;
  logic [5:0]        c_r;
  logic              c_en_r;

  // The MSB lives at index 0, so replicating bit 0 sign-extends.
  assign a_ext_s = {bus.A[0], bus.A};
  assign b_ext_s = {bus.B[0], bus.B};

  // Decode the active operation set and compute the result; unused opcode
  // fields never reach the selected branch.
  always_comb begin
    result_s = 6'sd0;
    legal_s  = 1'b0;
    case ({bus.a_en, bus.b_en})
      2'b10: begin
        legal_s = 1'b1;
        case (bus.a_op)
          3'd0:    result_s = a_ext_s + b_ext_s;
          3'd1:    result_s = a_ext_s - b_ext_s;
          3'd2:    result_s = a_ext_s ^ b_ext_s;
          3'd3:    result_s = a_ext_s & b_ext_s;
          3'd4:    result_s = a_ext_s | b_ext_s;
          3'd5:    result_s = ~(a_ext_s ^ b_ext_s);
          default: begin
            result_s = 6'sd0;
            legal_s  = 1'b0;
          end
        endcase
      end
      2'b01: begin
        legal_s = 1'b1;
        case (bus.b_op)
          2'd0:    result_s = ~(a_ext_s & b_ext_s);
          2'd1:    result_s = a_ext_s + b_ext_s;
          2'd2:    result_s = a_ext_s + b_ext_s;
          default: begin
            result_s = 6'sd0;
            legal_s  = 1'b0;
          end
        endcase
      end
      2'b11: begin
        legal_s = 1'b1;
        case (bus.b_op)
          2'd0:    result_s = a_ext_s ^ b_ext_s;
          2'd1:    result_s = ~(a_ext_s ^ b_ext_s);
          2'd2:    result_s = a_ext_s - 6'sd1;
          default: result_s = b_ext_s + 6'sd2;
        endcase
      end
      default: begin
        result_s = 6'sd0;
        legal_s  = 1'b0;
      end
    endcase
  end

  // Output registers: illegal ops clear C, a disabled cycle holds C.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_r    <= 6'd0;
      c_en_r <= 1'b0;
    end else if (bus.ALU_en) begin
      c_r    <= legal_s ? result_s : 6'd0;
      c_en_r <= legal_s;
    end else begin
      c_r    <= c_r;
      c_en_r <= 1'b0;
    end
  end

  assign bus.C    = c_r;
  assign bus.C_en = c_en_r;

endmodule

// File: tb/tb_alu_design.sv
// Directed self-checking bench for alu_design with hand-computed expectations.
module tb_alu_design;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  alu_design_if bus ();

  alu_design dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int exp_c, input logic exp_en);
    logic [5:0] e;
    e = exp_c[5:0];
    n_checks++;
    assert (bus.C === e && bus.C_en === exp_en) begin
      n_pass++;
    end else begin
      $display("FAIL %s: C=%0d C_en=%b, expected C=%0d C_en=%b",
               tag, $signed(bus.C), bus.C_en, $signed(e), exp_en);
      $error("%s observed %h/%b expected %h/%b", tag, bus.C, bus.C_en, e, exp_en);
    end
  endtask

  task automatic drive(input logic en, input logic ae, input logic be,
                       input int aop, input int bop, input int a, input int b);
    bus.ALU_en = en;
    bus.a_en   = ae;
    bus.b_en   = be;
    bus.a_op   = aop[2:0];
    bus.b_op   = bop[1:0];
    bus.A      = a[4:0];
    bus.B      = b[4:0];
  endtask

  // Apply inputs, clock once, then sample just after the edge.
  task automatic step(input string tag, input logic en, input logic ae, input logic be,
                      input int aop, input int bop, input int a, input int b,
                      input int exp_c, input logic exp_en);
    drive(en, ae, be, aop, bop, a, b);
    @(posedge clk);
    #1;
    check(tag, exp_c, exp_en);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
    #2;
    check("reset_state", 0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // Back-to-back B1 adds
    step("b1_add_5_3", 1'b1, 1'b0, 1'b1, 7, 1, 5, 3, 8, 1'b1);
    step("b1_add_6_4", 1'b1, 1'b0, 1'b1, 7, 1, 6, 4, 10, 1'b1);
    step("b1_add_7_5", 1'b1, 1'b0, 1'b1, 7, 1, 7, 5, 12, 1'b1);
    step("hold_disabled", 1'b0, 1'b1, 1'b0, 0, 0, 1, 1, 12, 1'b0);
    step("b1_add_8_6", 1'b1, 1'b0, 1'b1, 0, 1, 8, 6, 14, 1'b1);

    // X on inputs while disabled must not disturb the held result
    bus.ALU_en = 1'b0;
    bus.A = 5'bx; bus.B = 5'bz; bus.a_op = 3'bx; bus.a_en = 1'bx;
    @(posedge clk);
    #1;
    check("hold_x_inputs", 14, 1'b0);

    // Asynchronous reset mid-cycle discards the result
    drive(1'b1, 1'b0, 1'b1, 0, 2, 3, 3);
    @(posedge clk);
    #3;
    check("pre_reset_b1_op2", 6, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset", 0, 1'b0);
    #2;
    rst_n = 1'b1;
    step("post_reset_9_7", 1'b1, 1'b0, 1'b1, 0, 1, 9, 7, 16, 1'b1);

    // Set A sweep, A=-16, B=15
    step("a_op0_add",  1'b1, 1'b1, 1'b0, 0, 3, -16, 15, -1, 1'b1);
    step("a_op1_sub",  1'b1, 1'b1, 1'b0, 1, 3, -16, 15, -31, 1'b1);
    step("a_op2_xor",  1'b1, 1'b1, 1'b0, 2, 3, -16, 15, -1, 1'b1);
    step("a_op3_and",  1'b1, 1'b1, 1'b0, 3, 3, -16, 15, 0, 1'b1);
    step("a_op4_or",   1'b1, 1'b1, 1'b0, 4, 3, -16, 15, -1, 1'b1);
    step("a_op5_xnor", 1'b1, 1'b1, 1'b0, 5, 3, -16, 15, 0, 1'b1);
    step("a_op6_bad",  1'b1, 1'b1, 1'b0, 6, 0, -16, 15, 0, 1'b0);
    step("a_op3_and2", 1'b1, 1'b1, 1'b0, 3, 0, 12, 10, 8, 1'b1);
    step("a_op7_bad",  1'b1, 1'b1, 1'b0, 7, 1, -16, 15, 0, 1'b0);

    // Set B2, A=15, B=15
    step("b2_op2_dec",  1'b1, 1'b1, 1'b1, 6, 2, 15, 15, 14, 1'b1);
    step("b2_op3_inc2", 1'b1, 1'b1, 1'b1, 6, 3, 15, 15, 17, 1'b1);
    step("b2_op0_xor",  1'b1, 1'b1, 1'b1, 0, 0, 15, 15, 0, 1'b1);
    step("b2_op1_xnor", 1'b1, 1'b1, 1'b1, 0, 1, 15, 15, -1, 1'b1);
    step("b2_op2_neg",  1'b1, 1'b1, 1'b1, 0, 2, -16, 0, -17, 1'b1);

    // B1 NAND and illegal combinations
    step("b1_op0_nand", 1'b1, 1'b0, 1'b1, 5, 0, 5, 3, -2, 1'b1);
    step("none_sel",    1'b1, 1'b0, 1'b0, 0, 1, 5, 3, 0, 1'b0);
    step("b1_op2_add",  1'b1, 1'b0, 1'b1, 0, 2, -16, -16, -32, 1'b1);
    step("b1_op3_bad",  1'b1, 1'b0, 1'b1, 0, 3, 5, 3, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_design.md
ALU_DESIGN -- requirements
Module: alu_design

Interface
REQ-001 The block SHALL have exactly one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ALU_en  input  1  global enable; high = evaluate this cycle.
REQ-005 A  input  5  signed two's-complement operand, range -16..15; index 0 is MSB.
REQ-006 B  input  5  signed two's-complement operand, range -16..15; index 0 is MSB.
REQ-007 a_en  input  1  selects operation set A; combines with b_en.
REQ-008 a_op  input  3  opcode for set A.
REQ-009 b_en  input  1  selects operation set B; combines with a_en.
REQ-010 b_op  input  2  opcode for set B1/B2.
REQ-011 C  output  6  registered signed result, range -32..31; index 0 is MSB.
REQ-012 C_en  output  1  registered valid flag for C.

Function
REQ-013 All operands SHALL be sign-extended to 6 bits before any operation; all results are 6-bit two's complement.
REQ-014 No result SHALL overflow: every operation is bounded within -32..31 by operand range.
REQ-015 Set A (a_en=1, b_en=0), by a_op: 0 A+B; 1 A-B; 2 A XOR B; 3 A AND B; 4 A OR B; 5 A XNOR B; 6 and 7 illegal.
REQ-016 Set B1 (a_en=0, b_en=1), by b_op: 0 A NAND B; 1 A+B; 2 A+B; 3 illegal.
REQ-017 Set B2 (a_en=1, b_en=1), by b_op: 0 A XOR B; 1 A XNOR B; 2 A-1; 3 B+2.
REQ-018 a_en=0 and b_en=0 SHALL be treated as illegal.
REQ-019 Opcode fields not selected by the active set SHALL be ignored.
REQ-020 Latency: inputs sampled on a rising clk edge SHALL appear on C and C_en after that same edge (one-cycle registered).
REQ-021 At a rising edge with ALU_en=1 and a legal operation, C SHALL take the result and C_en SHALL be 1.
REQ-022 At a rising edge with ALU_en=1 and an illegal operation, C SHALL be 0 and C_en SHALL be 0.
REQ-023 At a rising edge with ALU_en=0, C SHALL hold its previous value and C_en SHALL be 0, regardless of other inputs.
REQ-024 Back-to-back operations SHALL be accepted every cycle with no stall and no internal state beyond the output registers.
REQ-025 Changes in X or Z on inputs while ALU_en=0 SHALL NOT affect outputs.

Reset
REQ-026 While rst_n=0, C SHALL be 0 and C_en SHALL be 0, asserted immediately without waiting for a clock edge.
REQ-027 Reset asserted during operation SHALL discard the in-flight result.
REQ-028 After rst_n deasserts, the first rising edge with ALU_en=1 SHALL produce a valid result per REQ-021/REQ-022.

Verification
REQ-029 ALU_en=1, a_en=0, b_en=1, b_op=1, with A/B = 5/3, then 6/4, then 7/5 on consecutive edges -> C = 8, 10, 12 respectively, each one edge later, and C_en=1.
REQ-030 After REQ-029, ALU_en=0 for one edge -> C holds 12 and C_en=0; ALU_en=1 with A=8, B=6 -> C=14 and C_en=1.
REQ-031 rst_n pulsed low mid-stream, asynchronous to clk -> C=0 and C_en=0 immediately; after release, A=9, B=7, set B1 op 1 -> C=16.
REQ-032 Set A sweep with A=-16, B=15: op0 -> -1; op1 -> -31; op2 -> -1; op3 -> 0; op4 -> -1; op5 -> 0; op6 and op7 -> C=0, C_en=0.
REQ-033 Set B2 with A=15, B=15: op2 -> 14; op3 -> 17; op0 -> 0; op1 -> -1.
REQ-034 a_en=0, b_en=0, ALU_en=1 -> C=0 and C_en=0; set B1 op3 -> C=0 and C_en=0.
